// File: rtl/avalon_dpram_init.sv
// True-dual-port RAM with two Avalon-MM slave ports, one clock, and an optional post-reset clear sweep.
// Latency: READ_LATENCY (1 or 2) clken cycles from accepted read to readdatavalid; writes land on the accepting edge.
// Backpressure: waitrequest is high only while the clear sweep runs; clken=0 stalls everything and masks readdatavalid.
module avalon_dpram_init #(
   parameter int                DATA_W         = 32,
   parameter int                ADDR_W         = 10,
   parameter int                DEPTH          = 1024,
   parameter int                READ_LATENCY   = 1,
   parameter int                CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clken,
   input  logic [ADDR_W-1:0]     s1_address,
   input  logic                  s1_chipselect,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic [DATA_W/8-1:0]   s1_byteenable,
   input  logic [DATA_W-1:0]     s1_writedata,
   output logic [DATA_W-1:0]     s1_readdata,
   output logic                  s1_readdatavalid,
   output logic                  s1_waitrequest,
   input  logic [ADDR_W-1:0]     s2_address,
   input  logic                  s2_chipselect,
   input  logic                  s2_read,
   input  logic                  s2_write,
   input  logic [DATA_W/8-1:0]   s2_byteenable,
   input  logic [DATA_W-1:0]     s2_writedata,
   output logic [DATA_W-1:0]     s2_readdata,
   output logic                  s2_readdatavalid,
   output logic                  s2_waitrequest,
   output logic                  init_done
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_cnt;
   logic              wait_q;
   logic              done_q;

   logic [DATA_W-1:0] mem [DEPTH];

   // Per-port views so both ports share one description of the datapath
   logic [ADDR_W-1:0] p_addr [2];
   logic [NB-1:0]     p_be   [2];
   logic [DATA_W-1:0] p_wd   [2];
   logic [1:0]        p_cs, p_rd, p_wr;

   logic [1:0]        in_range, wr_acc, rd_acc;
   logic [IDX_W-1:0]  idx    [2];
   logic [DATA_W-1:0] rd_raw [2];

   logic [1:0]        vld_q;
   logic [DATA_W-1:0] dat_q  [2];

   assign p_addr[0] = s1_address;
   assign p_addr[1] = s2_address;
   assign p_be[0]   = s1_byteenable;
   assign p_be[1]   = s2_byteenable;
   assign p_wd[0]   = s1_writedata;
   assign p_wd[1]   = s2_writedata;
   assign p_cs      = {s2_chipselect, s1_chipselect};
   assign p_rd      = {s2_read, s1_read};
   assign p_wr      = {s2_write, s1_write};

   // Acceptance and raw array read; a read+write on one port counts only as a write
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         in_range[i] = ({1'b0, p_addr[i]} < (ADDR_W+1)'(DEPTH));
         idx[i]      = p_addr[i][IDX_W-1:0];
         wr_acc[i]   = p_cs[i] & p_wr[i] & clken & ~wait_q;
         rd_acc[i]   = p_cs[i] & p_rd[i] & ~p_wr[i] & clken & ~wait_q;
         rd_raw[i]   = in_range[i] ? mem[idx[i]] : '0;
      end
   end

   // Clear-sweep FSM: one word per enabled cycle, releases waitrequest the cycle after the last word
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
         clr_cnt <= '0;
         wait_q  <= (CLEAR_ON_RESET != 0);
         done_q  <= (CLEAR_ON_RESET == 0);
      end else if (clken && state == S_INIT) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state  <= S_RUN;
            wait_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   // Array writes: sweep fill, else byte-merged port writes where s1 owns any byte both ports hit
   always_ff @(posedge clk) begin
      if (!reset && clken) begin
         if (state == S_INIT) begin
            mem[clr_cnt] <= CLEAR_VALUE;
         end else begin
            for (int b = 0; b < NB; b++) begin
               if (wr_acc[1] && in_range[1] && p_be[1][b] &&
                   !(wr_acc[0] && in_range[0] && p_be[0][b] && p_addr[0] == p_addr[1]))
                  mem[idx[1]][b*8 +: 8] <= p_wd[1][b*8 +: 8];
               if (wr_acc[0] && in_range[0] && p_be[0][b])
                  mem[idx[0]][b*8 +: 8] <= p_wd[0][b*8 +: 8];
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [1:0]        vld1;
         logic [DATA_W-1:0] dat1 [2];

         // Two-stage read pipeline; output data register holds while no result arrives
         always_ff @(posedge clk) begin
            if (reset) begin
               vld1  <= '0;
               vld_q <= '0;
               for (int i = 0; i < 2; i++) begin
                  dat1[i]  <= '0;
                  dat_q[i] <= '0;
               end
            end else if (clken) begin
               for (int i = 0; i < 2; i++) begin
                  vld1[i]  <= rd_acc[i];
                  vld_q[i] <= vld1[i];
                  if (rd_acc[i]) dat1[i]  <= rd_raw[i];
                  if (vld1[i])   dat_q[i] <= dat1[i];
               end
            end
         end
      end else begin : g_lat1
         // Single-stage read pipeline; output data register holds while no result arrives
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_q <= '0;
               for (int i = 0; i < 2; i++) dat_q[i] <= '0;
            end else if (clken) begin
               for (int i = 0; i < 2; i++) begin
                  vld_q[i] <= rd_acc[i];
                  if (rd_acc[i]) dat_q[i] <= rd_raw[i];
               end
            end
         end
      end
   endgenerate

   assign s1_readdata      = dat_q[0];
   assign s2_readdata      = dat_q[1];
   assign s1_readdatavalid = vld_q[0] & clken;
   assign s2_readdatavalid = vld_q[1] & clken;
   assign s1_waitrequest   = (CLEAR_ON_RESET != 0) ? wait_q : 1'b0;
   assign s2_waitrequest   = (CLEAR_ON_RESET != 0) ? wait_q : 1'b0;
   assign init_done        = (CLEAR_ON_RESET != 0) ? done_q : 1'b1;

endmodule
